mixed_four_and: RTL and testbench

- Four-input AND built in mixed modelling style:
  - gate-level 2-input ANDs for the (a,b) and (c,d) pairs;
  - dataflow combine of the two pair results to produce the combinational result f;
  - behavioural clocked monitor around f.
- Used as a qualified-enable/all-conditions-true detector in control paths.
- The combinational output f has zero latency; the clocked side adds a registered copy, edge pulses and a saturating assertion counter.

---
 rtl/mixed_four_and.sv | 59 +++++
 tb/tb_mixed_four_and.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mixed_four_and.sv
// Four-input AND detector: gate-level pair ANDs, a dataflow combine, and a
// clocked monitor (registered copy, edge pulses, saturating high-cycle count).
module mixed_four_and #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             clr,
  output logic             f,
  output logic             f_q,
  output logic             f_rise,
  output logic             f_fall,
  output logic [CNT_W-1:0] hi_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ab;
  logic cd;
  logic f_q_d;

  // Pair ANDs as primitives so a 0 on either input dominates X/Z on the other.
  and u_and_ab (ab, a, b);
  and u_and_cd (cd, c, d);

  // Combine the pair results; valid with or without clock and during reset.
  assign f = ab & cd;

  // Registered copy of f and its one-cycle-delayed history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q   <= 1'b0;
      f_q_d <= 1'b0;
    end else begin
      f_q   <= f;
      f_q_d <= f_q;
    end
  end

  // Edge pulses decoded from the two history registers.
  assign f_rise = f_q & ~f_q_d;
  assign f_fall = ~f_q & f_q_d;

  // Count edges sampled with f high; clear wins, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt <= '0;
    end else if (clr) begin
      hi_cnt <= '0;
    end else if (f && (hi_cnt != CNT_MAX)) begin
      hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mixed_four_and.sv
// Directed plus randomized checks of mixed_four_and against a sample-history model.
module tb_mixed_four_and;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n, a, b, c, d, clr;
  logic       f8, fq8, rise8, fall8;
  logic [7:0] cnt8;
  logic       f2, fq2, rise2, fall2;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: queue of f values sampled at each clock edge since reset, plus counters.
  bit hist[$];
  int m_cnt8;
  int m_cnt2;

  always #5 clk = clk_en ? ~clk : 1'b0;

  mixed_four_and #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .f(f8), .f_q(fq8), .f_rise(rise8), .f_fall(fall8), .hi_cnt(cnt8)
  );

  mixed_four_and #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .f(f2), .f_q(fq2), .f_rise(rise2), .f_fall(fall2), .hi_cnt(cnt2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_f();
    if (a === 1'b0 || b === 1'b0 || c === 1'b0 || d === 1'b0) return 1'b0;
    if (a === 1'b1 && b === 1'b1 && c === 1'b1 && d === 1'b1) return 1'b1;
    return 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  task automatic check_all(input string tag);
    bit cur, prev;
    cur  = hist[hist.size()-1];
    prev = hist[hist.size()-2];
    chk({tag, "_f8"}, 32'(f8), 32'(exp_f()));
    chk({tag, "_f2"}, 32'(f2), 32'(exp_f()));
    chk({tag, "_fq"}, 32'(fq8), 32'(cur));
    chk({tag, "_rise"}, 32'(rise8), 32'(cur && !prev));
    chk({tag, "_fall"}, 32'(fall8), 32'(!cur && prev));
    chk({tag, "_cnt8"}, 32'(cnt8), 32'(m_cnt8));
    chk({tag, "_fq2"}, 32'(fq2), 32'(cur));
    chk({tag, "_cnt2"}, 32'(cnt2), 32'(m_cnt2));
  endtask

  // Advance one clock edge: update model from inputs at the edge, then check.
  task automatic tick(input string tag);
    bit fv;
    if (rst_n) begin
      fv = (exp_f() === 1'b1);
      hist.push_back(fv);
      if (hist.size() > 4) void'(hist.pop_front());
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (fv) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_abcd(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  initial begin
    logic [3:0] truth_in [6];
    logic       truth_f  [6];
    logic [3:0] v;
    int         exp_cnt2 [5];
    truth_in = '{4'b0000, 4'b1111, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
    truth_f  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_cnt2 = '{1, 2, 3, 3, 3};

    rst_n = 1'b0;
    clr   = 1'b0;
    set_abcd(4'b0000);
    model_reset();
    #10;
    check_all("reset");

    // Truth sequence with no clock and reset held.
    for (int i = 0; i < 6; i++) begin
      set_abcd(truth_in[i]);
      #10;
      chk($sformatf("truth%0d", i), 32'(f8), 32'(truth_f[i]));
      check_all("truth_rst");
    end

    // Exhaustive operand space.
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      set_abcd(v);
      #1;
      chk($sformatf("exh%0d", i), 32'(f8), 32'(v == 4'b1111));
    end

    a = 1'b0; b = 1'bx; c = 1'bx; d = 1'bx;
    #1;
    chk("a0_dominates_x", 32'(f8), 32'(0));

    // Release reset between edges, then start the clock.
    set_abcd(4'b0000);
    #2;
    rst_n  = 1'b1;
    clk_en = 1'b1;
    tick("idle");

    // Registered path: rise, hold, then drop b.
    set_abcd(4'b1111);
    tick("rise_e1");
    chk("rise_e1_fq", 32'(fq8), 32'(1));
    chk("rise_e1_pulse", 32'(rise8), 32'(1));
    tick("rise_e2");
    chk("rise_e2_pulse", 32'(rise8), 32'(0));
    tick("rise_e3");
    b = 1'b0;
    tick("fall_e1");
    chk("fall_e1_fq", 32'(fq8), 32'(0));
    chk("fall_e1_pulse", 32'(fall8), 32'(1));
    tick("fall_e2");
    chk("fall_e2_pulse", 32'(fall8), 32'(0));

    // Saturating counter on the 2-bit instance.
    clr = 1'b1;
    tick("cnt_clr0");
    clr = 1'b0;
    set_abcd(4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick($sformatf("sat%0d", i));
      chk($sformatf("sat%0d_const", i), 32'(cnt2), 32'(exp_cnt2[i]));
    end
    clr = 1'b1;
    tick("clr_with_f");
    chk("clr_with_f_const", 32'(cnt2), 32'(0));
    clr = 1'b0;

    // Async reset with f_q=1 and hi_cnt=2.
    tick("pre_rst1");
    tick("pre_rst2");
    chk("pre_rst_cnt2", 32'(cnt2), 32'(2));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_f", 32'(f8), 32'(1));
    chk("async_rst_fq", 32'(fq8), 32'(0));
    #2;
    rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst_fq", 32'(fq8), 32'(1));

    // Randomized operation with glitches, clears and occasional resets.
    for (int i = 0; i < 300; i++) begin
      set_abcd(4'($urandom));
      #2;
      chk("glitch_f", 32'(f8), 32'(exp_f()));
      a = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
